dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the pipelined Y86 core: the memory-side end of the load/store interface driven by the pipeline's memory stage. It accepts one 8-byte little-endian read or write request at a time over a valid/ready handshake, transfers it one byte per cycle against a 4096-byte array, and returns a single-cycle response with read data and an error flag. While busy it deasserts `req_ready`, which the pipeline control uses as a memory stall.

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the Y86 pipeline's load/store port.
// Accepts one 8-byte little-endian read or write at a time (valid/ready),
// moves it one byte per cycle against a MEM_BYTES byte array, and returns a
// single-cycle response strobe with read data and an address-error flag.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (array contents are not reset)
//   req_valid  request present
//   req_ready  high only when idle; low acts as the pipeline's memory stall
//   req_write  1 = store, 0 = load
//   req_addr   64-bit byte base address
//   req_wdata  store data, little-endian
//   rsp_valid  one-cycle response strobe per accepted request
//   rsp_rdata  load data (store: echoed write data, error: 0); held until next response
//   rsp_error  address error, qualified by rsp_valid
//
// Optional build macro: DMEM_PRELOAD_EN -- when defined, bytes 200/208/216/224
// start out holding 200/210/220/120; otherwise the array starts all zero.
module dmem_responder #(
    parameter int MEM_BYTES = 4096,
    parameter int MAX_ADDR  = MEM_BYTES - 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    typedef logic [7:0] mem_t [MEM_BYTES];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < MEM_BYTES; i++) m[i] = 8'h00;
`ifdef DMEM_PRELOAD_EN
        m[200] = 8'd200;
        m[208] = 8'd210;
        m[216] = 8'd220;
        m[224] = 8'd120;
`endif
        return m;
    endfunction

    // Power-up contents only; rst deliberately never touches the array.
    mem_t mem = mem_init();

    state_t        state, state_n;
    logic          write_q, err_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q, rbuf;
    logic [2:0]    k;

    logic          accept, bad_addr;
    logic [AW-1:0] idx;
    logic [7:0]    rd_byte;

    assign accept    = req_valid & req_ready;
    // Full 64-bit compare: any upper address bit set is an error.
    assign bad_addr  = req_addr > 64'(MAX_ADDR);
    // Legal bases never wrap, so the low address bits plus k suffice.
    assign idx       = addr_q + AW'(k);
    assign rd_byte   = mem[idx];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_error = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = bad_addr ? RESP : XFER;
            XFER:    if (k == 3'd7) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf      <= '0;
            k         <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    write_q <= req_write;
                    err_q   <= bad_addr;
                    addr_q  <= req_addr[AW-1:0];
                    wdata_q <= req_wdata;
                    k       <= '0;
                    if (bad_addr) rsp_rdata <= '0;
                end
                XFER: begin
                    k <= k + 3'd1;
                    if (!write_q) rbuf[{k, 3'b000} +: 8] <= rd_byte;
                    // Last byte lands in rbuf on this same edge, so splice it in directly.
                    if (k == 3'd7)
                        rsp_rdata <= write_q ? wdata_q : {rd_byte, rbuf[55:0]};
                end
                default: ;
            endcase
        end
    end

    // Gated by rst so a reset edge mid-transfer commits nothing further.
    always_ff @(posedge clk) begin
        if (!rst && state == XFER && write_q)
            mem[idx] <= wdata_q[{k, 3'b000} +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [63:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] mm [4096];   // reference array

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    // Reference: apply one request to the model, return the expected response.
    function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] d,
                                  output logic [63:0] rd, output logic er);
        rd = '0;
        er = (a > 64'd4088);
        if (!er) begin
            for (int i = 0; i < 8; i++) begin
                if (w) mm[int'(a) + i] = d[8*i +: 8];
                else   rd[8*i +: 8]   = mm[int'(a) + i];
            end
            if (w) rd = d;
        end
    endfunction

    // Driver: issue one request, return response and latency (edges from acceptance).
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = {$urandom, $urandom};
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata; er = rsp_error;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", rsp_error); end
    endtask

    task automatic test_preload();
        logic [63:0] rd, erd; logic er, eer; int lat;
        model(1'b0, 64'd216, '0, erd, eer);
        do_req(1'b0, 64'd216, '0, rd, er, lat);
        checks++; if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL preload_216 got=%h/%b want=%h/0", rd, er, erd); end
`ifdef DMEM_PRELOAD_EN
        checks++; if (rd !== 64'd220) begin errors++; $display("FAIL preload_value got=%h want=dc", rd); end
`else
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL preload_value got=%h want=0", rd); end
`endif
    endtask

    task automatic test_store_load();
        logic [63:0] rd, erd; logic er, eer; int lat;
        model(1'b1, 64'd200, 64'h0123456789ABCDEF, erd, eer);
        do_req(1'b1, 64'd200, 64'h0123456789ABCDEF, rd, er, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL store_latency got=%0d want=9", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_error got=%b want=0", er); end
        model(1'b0, 64'd200, '0, erd, eer);
        do_req(1'b0, 64'd200, '0, rd, er, lat);
        checks++; if (rd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL load_200 got=%h want=0123456789abcdef", rd); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL load_latency got=%0d want=9", lat); end
        checks++; if (dut.mem[200] !== 8'hEF) begin errors++; $display("FAIL mem200 got=%h want=ef", dut.mem[200]); end
    endtask

    task automatic test_boundary();
        logic [63:0] rd, erd; logic er, eer; int lat;
        model(1'b0, 64'd4088, '0, erd, eer);
        do_req(1'b0, 64'd4088, '0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== erd || lat !== 9) begin errors++; $display("FAIL rd_4088 got=%h/%b/%0d want=%h/0/9", rd, er, lat, erd); end
        do_req(1'b0, 64'd4089, '0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1) begin errors++; $display("FAIL rd_4089 got=%h/%b/%0d want=0/1/1", rd, er, lat); end
        do_req(1'b0, 64'h0000_0001_0000_0000, '0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 64'd0 || lat !== 1) begin errors++; $display("FAIL rd_hi got=%h/%b/%0d want=0/1/1", rd, er, lat); end
        // Illegal stores must not touch the array (upper bits alias to low addresses).
        do_req(1'b1, 64'h0000_0001_0000_0000 + 64'd4088, 64'hA5A5A5A5A5A5A5A5, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL wr_hi got=%h/%b want=0/1", rd, er); end
        do_req(1'b1, 64'd4095, 64'h5A5A5A5A5A5A5A5A, rd, er, lat);
        checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL wr_4095 got=%b/%0d want=1/1", er, lat); end
        model(1'b0, 64'd4088, '0, erd, eer);
        do_req(1'b0, 64'd4088, '0, rd, er, lat);
        checks++; if (rd !== erd) begin errors++; $display("FAIL array_unchanged got=%h want=%h", rd, erd); end
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, a, d; logic er, eer, w; int lat;
        for (int n = 0; n < 30; n++) begin
            w = 1'($urandom);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       a = 64'd4089 + 64'($urandom_range(0, 6));
                1:       a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
                default: a = 64'($urandom_range(0, 4088));
            endcase
            model(w, a, d, erd, eer);
            do_req(w, a, d, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat !== (eer ? 1 : 9)) begin
                errors++;
                $display("FAIL random_%0d w=%b a=%h got=%h/%b/%0d want=%h/%b/%0d", n, w, a, rd, er, lat, erd, eer, eer ? 1 : 9);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$]; logic [63:0] qd[$]; logic qe[$];
        logic [63:0] erd, ed; logic eer, ee, wr;
        wr = 1'b1;
        for (int c = 0; c < 62; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checks++;
                if (qd.size() == 0) begin errors++; $display("FAIL b2b_spurious_rsp cycle=%0d", c); end
                else begin
                    ed = qd.pop_front(); ee = qe.pop_front();
                    if (rsp_rdata !== ed || rsp_error !== ee) begin errors++; $display("FAIL b2b_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_error, ed, ee); end
                end
            end
            req_valid = 1'b1; req_write = wr;
            req_addr  = 64'd1024 + 64'(8 * $urandom_range(0, 3));
            req_wdata = {$urandom, $urandom};
            if (req_ready) begin
                acc.push_back(c);
                model(wr, req_addr, req_wdata, erd, eer);
                qd.push_back(erd); qe.push_back(eer);
                wr = ~wr;
            end
        end
        @(negedge clk) req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid && qd.size() != 0) begin
                ed = qd.pop_front(); ee = qe.pop_front();
                checks++;
                if (rsp_rdata !== ed || rsp_error !== ee) begin errors++; $display("FAIL b2b_drain got=%h/%b want=%h/%b", rsp_rdata, rsp_error, ed, ee); end
            end
            @(negedge clk);
        end
        checks++; if (acc.size() !== 7) begin errors++; $display("FAIL b2b_accepts got=%0d want=7", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++; if (acc[i] - acc[i-1] !== 10) begin errors++; $display("FAIL b2b_gap got=%0d want=10", acc[i] - acc[i-1]); end
        end
        checks++; if (qd.size() !== 0) begin errors++; $display("FAIL b2b_missing_rsp left=%0d want=0", qd.size()); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] rd, erd; logic er, eer; int lat, seen;
        model(1'b1, 64'd0, 64'd0, erd, eer);
        do_req(1'b1, 64'd0, 64'd0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd0; req_wdata = '1;
        @(posedge clk);                       // E
        @(negedge clk) req_valid = 1'b0;
        repeat (3) @(posedge clk);            // E+1..E+3: bytes 0..2
        @(negedge clk) rst = 1'b1;
        @(posedge clk);                       // E+4
        @(negedge clk) rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", req_ready); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_rsp got=%0d want=0", seen); end
        for (int i = 0; i < 8; i++) mm[i] = (i < 3) ? 8'hFF : 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.mem[i] !== mm[i]) begin errors++; $display("FAIL midrst_byte%0d got=%h want=%h", i, dut.mem[i], mm[i]); end
        end
        model(1'b0, 64'd0, '0, erd, eer);
        do_req(1'b0, 64'd0, '0, rd, er, lat);
        checks++; if (rd !== 64'h0000_0000_00FF_FFFF || rd !== erd) begin errors++; $display("FAIL midrst_read got=%h want=0000000000ffffff", rd); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
`ifdef DMEM_PRELOAD_EN
        mm[200] = 8'd200; mm[208] = 8'd210; mm[216] = 8'd220; mm[224] = 8'd120;
`endif
        test_reset();
        test_preload();
        test_store_load();
        test_boundary();
        test_random();
        test_back_to_back();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
